// File: rtl/spio_link_speed_pkg.sv
// Shared definitions for the SpiNNaker link speed converters.
//   PKT_BITS_DEFAULT : default packet width in bits
//   BUF_DEPTH        : entries in the rate-matching buffer
//   occ_t            : buffer occupancy (0..BUF_DEPTH)
package spio_link_speed_pkg;
    localparam int PKT_BITS_DEFAULT = 72;
    localparam int BUF_DEPTH        = 2;

    typedef logic [1:0] occ_t;
endpackage

// File: rtl/spio_link_speed_halver_buf.sv
// Two-entry FIFO used by the link speed halver.
// Ports:
//   CLK_IN, RESET_IN   clock, synchronous active-high reset
//   PUSH_IN, DATA_IN   write a packet at the tail
//   POP_IN             drop the head (only asserted when COUNT_OUT > 0)
//   HEAD_OUT           oldest entry
//   COUNT_OUT          current occupancy
//   COUNT_NEXT_OUT     occupancy after this edge's push/pop
module spio_link_speed_halver_buf
    import spio_link_speed_pkg::*;
#(
    parameter int PKT_BITS = PKT_BITS_DEFAULT
) (
    input  logic                CLK_IN,
    input  logic                RESET_IN,
    input  logic                PUSH_IN,
    input  logic                POP_IN,
    input  logic [PKT_BITS-1:0] DATA_IN,
    output logic [PKT_BITS-1:0] HEAD_OUT,
    output occ_t                COUNT_OUT,
    output occ_t                COUNT_NEXT_OUT
);

    logic [PKT_BITS-1:0] entry0;
    logic [PKT_BITS-1:0] entry1;
    occ_t                count_q;

    always_comb begin
        COUNT_NEXT_OUT = count_q;
        if (PUSH_IN && !POP_IN)
            COUNT_NEXT_OUT = count_q + 2'd1;
        else if (!PUSH_IN && POP_IN)
            COUNT_NEXT_OUT = count_q - 2'd1;
    end

    // entry0 is always the head; entries shift down on a pop.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            count_q <= '0;
            entry0  <= '0;
            entry1  <= '0;
        end else begin
            count_q <= COUNT_NEXT_OUT;
            if (POP_IN) begin
                if (count_q == 2'd2)
                    entry0 <= entry1;
                if (PUSH_IN) begin
                    if (count_q == 2'd2)
                        entry1 <= DATA_IN;
                    else
                        entry0 <= DATA_IN;
                end
            end else if (PUSH_IN) begin
                if (count_q == 2'd0)
                    entry0 <= DATA_IN;
                else
                    entry1 <= DATA_IN;
            end
        end
    end

    assign HEAD_OUT  = entry0;
    assign COUNT_OUT = count_q;

endmodule

// File: rtl/spio_link_speed_halver.sv
// Carries rdy/vld packets from a full-rate producer to a half-rate consumer.
// The output register only updates at the end of phase cycles, so DATA_OUT
// and VLD_OUT are stable for a whole slow period.
// Ports:
//   CLK_IN, RESET_IN          fast clock, synchronous active-high reset
//   PHASE_IN                  high in the fast cycle ending on a slow edge
//   DATA_IN, VLD_IN, RDY_OUT  fast-side packet interface
//   DATA_OUT, VLD_OUT, RDY_IN slow-side packet interface
//   PHASE_ERR_OUT             sticky phase error
// Build option: SPIO_LINK_SPEED_HALVER_PHASE_CHECK_EN builds the phase
// checker; without it PHASE_ERR_OUT is tied low.
module spio_link_speed_halver
    import spio_link_speed_pkg::*;
#(
    parameter int PKT_BITS = PKT_BITS_DEFAULT
) (
    input  logic                CLK_IN,
    input  logic                RESET_IN,
    input  logic                PHASE_IN,
    input  logic [PKT_BITS-1:0] DATA_IN,
    input  logic                VLD_IN,
    output logic                RDY_OUT,
    output logic [PKT_BITS-1:0] DATA_OUT,
    output logic                VLD_OUT,
    input  logic                RDY_IN,
    output logic                PHASE_ERR_OUT
);

    logic                locked;
    logic                locked_next;
    logic                push;
    logic                pop;
    logic                out_load;
    logic [PKT_BITS-1:0] head_data;
    occ_t                count;
    occ_t                count_next;

    assign locked_next = locked | PHASE_IN;
    assign push        = VLD_IN & RDY_OUT;
    assign out_load    = PHASE_IN & (~VLD_OUT | RDY_IN);
    assign pop         = out_load & (count != 2'd0);

    spio_link_speed_halver_buf #(
        .PKT_BITS (PKT_BITS)
    ) u_buf (
        .CLK_IN         (CLK_IN),
        .RESET_IN       (RESET_IN),
        .PUSH_IN        (push),
        .POP_IN         (pop),
        .DATA_IN        (DATA_IN),
        .HEAD_OUT       (head_data),
        .COUNT_OUT      (count),
        .COUNT_NEXT_OUT (count_next)
    );

    // RDY_OUT looks ahead at the post-edge occupancy so it never admits a
    // packet into a full buffer.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            locked   <= 1'b0;
            RDY_OUT  <= 1'b0;
            VLD_OUT  <= 1'b0;
            DATA_OUT <= '0;
        end else begin
            locked  <= locked_next;
            RDY_OUT <= locked_next && (count_next < occ_t'(BUF_DEPTH));
            if (out_load) begin
                if (count != 2'd0) begin
                    DATA_OUT <= head_data;
                    VLD_OUT  <= 1'b1;
                end else begin
                    VLD_OUT  <= 1'b0;
                end
            end
        end
    end

`ifdef SPIO_LINK_SPEED_HALVER_PHASE_CHECK_EN
    logic phase_q;
    logic phase_q_vld;
    logic phase_err;

    // PHASE_IN must alternate; two equal samples in a row is an error.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            phase_q     <= 1'b0;
            phase_q_vld <= 1'b0;
            phase_err   <= 1'b0;
        end else if (locked) begin
            phase_q     <= PHASE_IN;
            phase_q_vld <= 1'b1;
            if (phase_q_vld && (phase_q == PHASE_IN))
                phase_err <= 1'b1;
        end
    end

    assign PHASE_ERR_OUT = phase_err;
`else
    assign PHASE_ERR_OUT = 1'b0;
`endif

endmodule

// File: doc/spio_link_speed_halver.md
# spio_link_speed_halver

Carries rdy/vld packets from a full-rate producer to a consumer that samples only once every two `CLK_IN` cycles (a half-rate domain derived from `CLK_IN`). It is the companion of the link speed doubler, covering the opposite direction. It sits between fast-clocked link logic and half-rate link-speed interfaces. A 2-entry buffer absorbs the rate mismatch. Outputs only change on slow-cycle boundaries, so they are stable for a full slow period.

## Interface
- `PKT_BITS`, default 72: packet width in bits.
- `CLK_IN`  in  1  fast clock; the half-rate domain edges coincide with alternate `CLK_IN` rising edges.
- `RESET_IN`  in  1  reset; one clock; reset is synchronous and active-high.
- `PHASE_IN`  in  1  high in the fast cycle whose ending edge is also a slow-domain rising edge; nominally toggles every cycle.
- `DATA_IN`  in  `PKT_BITS`  fast-side packet.
- `VLD_IN`  in  1  fast-side valid.
- `RDY_OUT`  out  1  fast-side ready; registered.
- `DATA_OUT`  out  `PKT_BITS`  slow-side packet; registered.
- `VLD_OUT`  out  1  slow-side valid; registered.
- `RDY_IN`  in  1  slow-side ready; sampled only in phase cycles.
- `PHASE_ERR_OUT`  out  1  sticky phase-error flag (see Configuration).

## Operation
- Lock:
  - `locked` clears on reset.
  - `locked` sets at the end of the first cycle with `PHASE_IN`=1.
  - While unlocked, `RDY_OUT`=0 and `VLD_OUT`=0.
- Fast-side transfer: at an edge with `VLD_IN && RDY_OUT`, the packet is pushed into the buffer tail.
- Buffer: 2-entry FIFO, occupancy `count` in 0..2. The head is the oldest entry.
- Slow-side transfer completes at the end of a phase cycle when `VLD_OUT && RDY_IN`.
- Output register update happens only at the end of phase cycles. In all other cycles `DATA_OUT` and `VLD_OUT` hold.
  - If `!VLD_OUT || RDY_IN`: when `count`>0, load the head into `DATA_OUT`, set `VLD_OUT`=1 and pop. When `count`=0, set `VLD_OUT`=0. `DATA_OUT` then holds its last value and is don't-care.
  - Otherwise hold (stall).
- Push and pop at the same edge: `count` is unchanged. The head advances and the new packet goes to the tail.
- A push into a buffer with `count`=0 at a popping edge is not bypassed. The packet waits for the next phase edge.
- `RDY_OUT` next value is `locked_next && (count_next < 2)`, with `count_next` including that edge's push and pop. `RDY_OUT` is therefore exact and never accepts into a full buffer.
- Protocol rules:
  - The producer holds `DATA_IN` stable while `VLD_IN && !RDY_OUT`.
  - The slow consumer holds `RDY_IN` constant across each slow period.

## Timing
- Reset values: `RDY_OUT`=0, `VLD_OUT`=0, `DATA_OUT`=0, `PHASE_ERR_OUT`=0, `count`=0, `locked`=0.
- Reset asserted mid-operation discards all buffered and presented packets at that edge.
- First `RDY_OUT`=1 is the cycle after the first phase cycle following reset release.
- Minimum latency: a packet pushed at the end of cycle t, with t+1 a phase cycle and the output free, gives `VLD_OUT`=1 in cycle t+2.
- Maximum latency, output free: 3 cycles (pushed at the end of a phase cycle).
- Sustained throughput: one packet per slow cycle.
  - The producer sees `RDY_OUT` drop once `count`=2.
  - `RDY_OUT` rises the cycle after a pop frees an entry.
- Output stall: with `RDY_IN`=0, `VLD_OUT`/`DATA_OUT` stay unchanged indefinitely. The buffer fills to 2 and `RDY_OUT` falls.

## Configuration
- `SPIO_LINK_SPEED_HALVER_PHASE_CHECK_EN` defined:
  - A checker registers `PHASE_IN` each cycle once locked.
  - `PHASE_ERR_OUT` sets, and stays set until reset, the cycle after two consecutive cycles have equal `PHASE_IN` values.
- Not defined: no checker logic is built and `PHASE_ERR_OUT` is tied to 0.
- Data path behaviour is identical in both builds.

## Structure
- Shared package `spio_link_speed_pkg`:
  - default packet width constant (72);
  - buffer depth constant (2);
  - occupancy type (2 bits).
- One sub-module, `spio_link_speed_halver_buf`: 2-entry FIFO with push, pop, head data, `count` and `count_next` outputs.
- Lock, output register, `RDY_OUT` and phase checker live in the top level.

## Test plan
- Lock:
  - Stimulus: release reset with `PHASE_IN`=0 for 3 cycles, then start toggling.
  - Required: `RDY_OUT`=0 until the cycle after the first `PHASE_IN`=1 cycle, then `RDY_OUT`=1.
- Single packet:
  - Stimulus: `VLD_IN`=1 with `DATA_IN`=0x12_3456_789A_BCDE_F012 for one accepted cycle, with the next cycle a phase cycle.
  - Required: `VLD_OUT`=1 and the same data 2 cycles later; `VLD_OUT` held exactly 2 cycles with `RDY_IN`=1.
- Full-rate burst:
  - Stimulus: 8 packets (1..8) offered back-to-back, `RDY_IN`=1.
  - Required: all 8 emerge in order, one per slow cycle; `RDY_OUT` toggles once `count` reaches 2; no loss or duplication.
- Stall:
  - Stimulus: `RDY_IN`=0 while packets 1..4 are offered.
  - Required: `DATA_OUT`=1 held, `count`=2, `RDY_OUT`=0. After `RDY_IN`=1, packets 1,2,3 emerge on consecutive slow cycles, then 4.
- Reset mid-burst:
  - Stimulus: assert `RESET_IN` for 1 cycle with `count`=2 and `VLD_OUT`=1.
  - Required: next cycle all outputs at reset values; no old packet reappears after relock.
- Phase check (macro defined):
  - Stimulus: hold `PHASE_IN`=1 for 2 cycles after lock.
  - Required: `PHASE_ERR_OUT`=1 the following cycle and it stays 1. With the macro undefined, it stays 0.
